regfile_param: RTL and testbench

Parametrised successor to the team's 32x32 two-read/one-write register file, used in the single-cycle and pipelined CPU datapaths. It generalises width and depth, and adds an asynchronous clear, per-byte write enables, and an optional hardwired zero register. It also adds optional write-to-read forwarding and an optional registered-read (1-cycle latency) mode for the pipelined core.

---
 rtl/regfile_param.sv | 119 +++++++++++
 tb/tb_regfile_param.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file with byte-lane writes,
// optional hardwired zero entry, write-to-read forwarding and registered reads.
module regfile_param #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          READ_REG = 1'b0
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic [AW-1:0]       Rn1,
  input  logic [AW-1:0]       Rn2,
  input  logic [AW-1:0]       Wn,
  input  logic                Write,
  input  logic [DW/8-1:0]     WrBe,
  input  logic [DW-1:0]       Wd,
  output logic [DW-1:0]       A,
  output logic [DW-1:0]       B
);

  localparam int unsigned NB    = DW / 8;
  localparam int unsigned DEPTH = 32'd1 << AW;

  logic [DW-1:0] mem_r [DEPTH];
  logic          wr_eff_s;
  logic [DW-1:0] ent_a_s, ent_b_s;
  logic [DW-1:0] m_a_s, m_b_s;

  // Replace the enabled byte lanes of an entry with the incoming write data
  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] cur,
                                                input logic [DW-1:0] wd,
                                                input logic [NB-1:0] be);
    logic [DW-1:0] res;
    res = cur;
    for (int i = 0; i < int'(NB); i++) begin
      if (be[i]) begin
        res[8*i +: 8] = wd[8*i +: 8];
      end else begin
        res[8*i +: 8] = cur[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Qualify the write: held-in-reset and zero-entry writes are dropped
  always_comb begin
    wr_eff_s = 1'b0;
    if (Write && Resetn) begin
      if (ZERO_REG && (Wn == '0)) begin
        wr_eff_s = 1'b0;
      end else begin
        wr_eff_s = 1'b1;
      end
    end else begin
      wr_eff_s = 1'b0;
    end
  end

  // Storage array with asynchronous clear
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_eff_s) begin
      mem_r[Wn] <= merge_lanes(mem_r[Wn], Wd, WrBe);
    end
  end

  // Stored and write-merged views of both read addresses
  always_comb begin
    ent_a_s = mem_r[Rn1];
    ent_b_s = mem_r[Rn2];
    if (ZERO_REG && (Rn1 == '0)) begin
      ent_a_s = '0;
    end else begin
      ent_a_s = mem_r[Rn1];
    end
    if (ZERO_REG && (Rn2 == '0)) begin
      ent_b_s = '0;
    end else begin
      ent_b_s = mem_r[Rn2];
    end
    // wr_eff_s already excludes entry 0, so a zeroed read is never merged
    if (wr_eff_s && (Wn == Rn1)) begin
      m_a_s = merge_lanes(ent_a_s, Wd, WrBe);
    end else begin
      m_a_s = ent_a_s;
    end
    if (wr_eff_s && (Wn == Rn2)) begin
      m_b_s = merge_lanes(ent_b_s, Wd, WrBe);
    end else begin
      m_b_s = ent_b_s;
    end
  end

  if (READ_REG) begin : g_reg_read
    logic [DW-1:0] a_r, b_r;

    // Write-first registered read ports
    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
        a_r <= '0;
        b_r <= '0;
      end else begin
        a_r <= m_a_s;
        b_r <= m_b_s;
      end
    end

    assign A = a_r;
    assign B = b_r;
  end else begin : g_comb_read
    assign A = BYPASS ? m_a_s : ent_a_s;
    assign B = BYPASS ? m_b_s : ent_b_s;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three parameterisations share one stimulus stream
// and are checked every cycle against an array-based reference model.
module tb_regfile_param;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [4:0]  rn1, rn2, wn;
  logic        write;
  logic [3:0]  wrbe;
  logic [31:0] wd;
  logic [31:0] a0, b0, a1, b1;
  logic [15:0] a2, b2;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_on = 1'b0;

  logic [31:0] m0 [32];
  logic [31:0] m1 [32];
  logic [31:0] m2 [8];
  logic [15:0] exp_a2, exp_b2;

  always #5 Clock = ~Clock;

  // d0: defaults (zero reg, bypass, comb read)
  regfile_param #(.DW(32), .AW(5), .ZERO_REG(1'b1), .BYPASS(1'b1), .READ_REG(1'b0)) u_d0 (
    .Clock(Clock), .Resetn(Resetn), .Rn1(rn1), .Rn2(rn2), .Wn(wn), .Write(write),
    .WrBe(wrbe), .Wd(wd), .A(a0), .B(b0));

  // d1: no zero reg, no bypass
  regfile_param #(.DW(32), .AW(5), .ZERO_REG(1'b0), .BYPASS(1'b0), .READ_REG(1'b0)) u_d1 (
    .Clock(Clock), .Resetn(Resetn), .Rn1(rn1), .Rn2(rn2), .Wn(wn), .Write(write),
    .WrBe(wrbe), .Wd(wd), .A(a1), .B(b1));

  // d2: 16-bit, 8-entry, registered read
  regfile_param #(.DW(16), .AW(3), .ZERO_REG(1'b1), .BYPASS(1'b1), .READ_REG(1'b1)) u_d2 (
    .Clock(Clock), .Resetn(Resetn), .Rn1(rn1[2:0]), .Rn2(rn2[2:0]), .Wn(wn[2:0]), .Write(write),
    .WrBe(wrbe[1:0]), .Wd(wd[15:0]), .A(a2), .B(b2));

  // Value seen at addr: 0 for a hardwired zero entry, else cur with any same-address write merged
  function automatic logic [31:0] mval(input logic [31:0] cur, input logic [4:0] addr,
                                       input logic [4:0] waddr, input logic we,
                                       input logic [3:0] be, input logic [31:0] d,
                                       input logic zr);
    logic [31:0] r;
    r = cur;
    if (zr && addr == 5'd0) return 32'd0;
    if (we && !(zr && waddr == 5'd0) && waddr == addr)
      for (int i = 0; i < 4; i++)
        if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 32; i++) begin
        m0[i] <= 32'd0;
        m1[i] <= 32'd0;
      end
      for (int i = 0; i < 8; i++) m2[i] <= 32'd0;
      exp_a2 <= 16'd0;
      exp_b2 <= 16'd0;
    end else begin
      exp_a2 <= 16'(mval(m2[rn1[2:0]], {2'b00, rn1[2:0]}, {2'b00, wn[2:0]}, write,
                         {2'b00, wrbe[1:0]}, {16'h0000, wd[15:0]}, 1'b1));
      exp_b2 <= 16'(mval(m2[rn2[2:0]], {2'b00, rn2[2:0]}, {2'b00, wn[2:0]}, write,
                         {2'b00, wrbe[1:0]}, {16'h0000, wd[15:0]}, 1'b1));
      if (write) begin
        m0[wn] <= mval(m0[wn], wn, wn, 1'b1, wrbe, wd, 1'b1);
        m1[wn] <= mval(m1[wn], wn, wn, 1'b1, wrbe, wd, 1'b0);
        m2[wn[2:0]] <= mval(m2[wn[2:0]], {2'b00, wn[2:0]}, {2'b00, wn[2:0]}, 1'b1,
                            {2'b00, wrbe[1:0]}, {16'h0000, wd[15:0]}, 1'b1);
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle
  always @(negedge Clock) begin
    if (chk_on) begin
      check("cmp_a0", a0, mval(m0[rn1], rn1, wn, write & Resetn, wrbe, wd, 1'b1));
      check("cmp_b0", b0, mval(m0[rn2], rn2, wn, write & Resetn, wrbe, wd, 1'b1));
      check("cmp_a1", a1, m1[rn1]);
      check("cmp_b1", b1, m1[rn2]);
      check("cmp_a2", {16'h0000, a2}, {16'h0000, exp_a2});
      check("cmp_b2", {16'h0000, b2}, {16'h0000, exp_b2});
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    write = 1'b1; wn = a; wd = d; wrbe = be;
    step();
    write = 1'b0;
  endtask

  initial begin
    Resetn = 1'b1; write = 1'b0; wn = 5'd0; wd = 32'd0; wrbe = 4'h0;
    rn1 = 5'd0; rn2 = 5'd0;
    #2 Resetn = 1'b0;
    chk_on = 1'b1;
    step(); step();
    #2;
    check("rst_a0", a0, 32'd0);
    check("rst_b1", b1, 32'd0);
    check("rst_a2", {16'h0000, a2}, 32'd0);
    Resetn = 1'b1;

    // basic write then comb read
    wr(5'd4, 32'd511, 4'hF);
    rn1 = 5'd4; #2;
    check("t1_a0", a0, 32'd511);
    check("t1_a1", a1, 32'd511);
    wr(5'd8, 32'd811, 4'hF);
    rn2 = 5'd8; #2;
    check("t1_b0", b0, 32'd811);

    // byte lanes
    wr(5'd5, 32'h11223344, 4'hF);
    wr(5'd5, 32'hAABBCCDD, 4'b0101);
    rn1 = 5'd5; #2;
    check("be_a0", a0, 32'h11BB33DD);
    check("be_model", m0[5], 32'h11BB33DD);

    // zero register
    wr(5'd0, 32'hFFFFFFFF, 4'hF);
    rn1 = 5'd0; rn2 = 5'd0; #2;
    check("z_a0", a0, 32'd0);
    check("z_b0", b0, 32'd0);
    check("z_a1", a1, 32'hFFFFFFFF);

    // forwarding
    wr(5'd3, 32'd100, 4'hF);
    write = 1'b1; wn = 5'd3; wd = 32'd200; wrbe = 4'hF; rn1 = 5'd3; #2;
    check("fw_a0", a0, 32'd200);
    check("fw_a1_pre", a1, 32'd100);
    step();
    write = 1'b0; #2;
    check("fw_a1_post", a1, 32'd200);

    // registered read
    write = 1'b1; wn = 5'd7; wd = 32'h00001234; wrbe = 4'hF; rn1 = 5'd7; #2;
    check("rr_pre", {16'h0000, a2}, 32'd200);
    step();
    write = 1'b0; #2;
    check("rr_post", {16'h0000, a2}, 32'h00001234);
    rn1 = 5'd4; #2;
    check("rr_hold", {16'h0000, a2}, 32'h00001234);
    step(); #2;
    check("rr_move", {16'h0000, a2}, 32'h000001FF);

    // async reset mid-write
    wr(5'd1, 32'd1, 4'hF);
    wr(5'd2, 32'd2, 4'hF);
    wr(5'd3, 32'd3, 4'hF);
    rn1 = 5'd1; rn2 = 5'd3; #2;
    check("ar_pre_a0", a0, 32'd1);
    write = 1'b1; wn = 5'd2; wd = 32'd99; wrbe = 4'hF;
    #1 Resetn = 1'b0;
    #1;
    check("ar_a0", a0, 32'd0);
    check("ar_b0", b0, 32'd0);
    check("ar_a1", a1, 32'd0);
    step();
    Resetn = 1'b1; write = 1'b0; rn1 = 5'd2; #2;
    check("ar_r2", a0, 32'd0);
    check("ar_r3", b1, 32'd0);

    // mixed traffic, checked by the per-cycle compare
    for (int k = 0; k < 40; k++) begin
      write = 1'($urandom_range(0, 1));
      wn    = 5'($urandom_range(0, 9));
      wd    = $urandom;
      wrbe  = 4'($urandom_range(0, 15));
      rn1   = 5'($urandom_range(0, 9));
      rn2   = 5'($urandom_range(0, 9));
      step();
    end
    write = 1'b0;
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
